timer_arbiter: RTL

//   Shares one down-counting interval timer among N requesters using round-robin arbitration.

---
 rtl/timer_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared down-counting interval timer, round-robin among N requesters.
// Build option TIMER_ABORT_EN lets abort cancel a running interval.
module timer_arbiter #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*WIDTH-1:0] k,
  input  logic             abort,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic             busy,
  output logic [IW-1:0]    cur_id,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic [N-1:0]  win_oh;
  logic          any;

`ifndef TIMER_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  // Scan downward so the nearest requester after last is written last.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % N);
      if (req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
    win_oh = '0;
    win_oh[win] = any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      q      <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      cur_id <= '0;
      last   <= IW'(N - 1);
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any) begin
            state  <= S_RUN;
            cur_id <= win;
            q      <= k[int'(win)*WIDTH +: WIDTH];
            gnt    <= win_oh;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
`ifdef TIMER_ABORT_EN
          if (abort) begin
            q     <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            last  <= cur_id;
            state <= S_IDLE;
          end else if (q == '0) begin
            done  <= gnt;
            state <= S_DONE;
          end else begin
            q <= q - WIDTH'(1);
          end
`else
          if (q == '0) begin
            done  <= gnt;
            state <= S_DONE;
          end else begin
            q <= q - WIDTH'(1);
          end
`endif
        end
        S_DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          last  <= cur_id;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
